// File: rtl/fsm_mealy_pkg.sv
// Shared constants and elaboration-time helpers for the serial Mealy pattern detector.
// The transition function is evaluated only on constants, so it folds into a lookup table.
package fsm_mealy_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [15:0] DEF_PATTERN = 16'b1011;
  localparam int unsigned MAX_PAT_LEN = 16;

  function automatic int unsigned state_width(input int unsigned pat_len);
    return (pat_len <= 2) ? 1 : $clog2(pat_len);
  endfunction

  // Bit i of the pattern in arrival order; the first bit received is pattern[pat_len-1].
  function automatic logic pat_bit(input logic [15:0] pattern, input int unsigned pat_len,
                                   input int unsigned i);
    return pattern[4'(pat_len - 1 - i)];
  endfunction

  function automatic int unsigned next_state(input int unsigned k, input logic b,
                                             input logic [15:0] pattern,
                                             input int unsigned pat_len, input bit overlap);
    logic [16:0] s;
    bit          ok;
    if (k >= pat_len) return 0;
    if (k < pat_len - 1 && b == pat_bit(pattern, pat_len, k)) return k + 1;
    if (k == pat_len - 1 && b == pat_bit(pattern, pat_len, k) && !overlap) return 0;
    // s holds the matched prefix followed by b; pick the longest suffix that is a prefix.
    s = '0;
    for (int unsigned i = 0; i < k; i++) s[5'(i)] = pat_bit(pattern, pat_len, i);
    s[5'(k)] = b;
    for (int unsigned j = k; j > 0; j--) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < j; i++)
        if (s[5'(k + 1 - j + i)] != pat_bit(pattern, pat_len, i)) ok = 1'b0;
      if (ok) return j;
    end
    return 0;
  endfunction

endpackage

// File: rtl/fsm_mealy.sv
// Serial-bit Mealy sequence detector: outp flags the bit that completes PATTERN.
// Transitions come from a table built at elaboration; runtime logic is a lookup and compare.
module fsm_mealy
  import fsm_mealy_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN,
  parameter logic [15:0] PATTERN = DEF_PATTERN,
  parameter int unsigned OVERLAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic inp,
  output logic outp
);

  localparam int unsigned   SW       = state_width(PAT_LEN);
  localparam int unsigned   NS       = 1 << SW;
  localparam logic [SW-1:0] LAST     = SW'(PAT_LEN - 1);
  localparam logic          LAST_BIT = PATTERN[0];

  typedef logic [SW-1:0] state_t;

  state_t state;
  state_t nxt;
  state_t tbl0 [NS];
  state_t tbl1 [NS];

  // Unused encodings (PAT_LEN not a power of two) map back to S0 so nothing can stick there.
  for (genvar g = 0; g < NS; g++) begin : g_tbl
    localparam state_t N0 = SW'(next_state(g, 1'b0, PATTERN, PAT_LEN, OVERLAP != 0));
    localparam state_t N1 = SW'(next_state(g, 1'b1, PATTERN, PAT_LEN, OVERLAP != 0));
    assign tbl0[g] = N0;
    assign tbl1[g] = N1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= '0;
    else      state <= nxt;
  end

  always_comb begin
    nxt  = state;
    outp = 1'b0;
    nxt  = inp ? tbl1[state] : tbl0[state];
    outp = rst && (state == LAST) && (inp == LAST_BIT);
  end

endmodule

// File: tb/tb_fsm_mealy.sv
// Scoreboard bench: three detector configurations driven by one bit stream, checked per cycle.
module tb_fsm_mealy;

  localparam int unsigned ND        = 3;
  localparam int unsigned LEN [ND]  = '{4, 4, 5};
  localparam logic [15:0] PAT [ND]  = '{16'b1011, 16'b1011, 16'b11011};
  localparam bit          OVL [ND]  = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inp = 1'b0;
  logic outp_a, outp_b, outp_c;

  always #5 clk = ~clk;

  fsm_mealy #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(1)) dut_a (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_a));
  fsm_mealy #(.PAT_LEN(4), .PATTERN(16'b1011), .OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_b));
  fsm_mealy #(.PAT_LEN(5), .PATTERN(16'b11011), .OVERLAP(1)) dut_c (
    .clk(clk), .rst(rst), .inp(inp), .outp(outp_c));

  typedef struct {
    logic [ND-1:0] exp;
    int unsigned   n;
    string         tag;
  } ent_t;

  ent_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  string       cur_tag = "init";

  // Reference: history of bits received since the last reset/restart, compared to the pattern.
  logic [15:0] hist  [ND];
  int unsigned since [ND];

  function automatic logic model_out(input int unsigned d, input logic b, input logic r);
    logic [15:0] w;
    logic [15:0] mask;
    if (!r || since[d] + 1 < LEN[d]) return 1'b0;
    w    = {hist[d][14:0], b};
    mask = 16'((32'd1 << LEN[d]) - 1);
    return ((w ^ PAT[d]) & mask) == '0;
  endfunction

  task automatic send(input logic b, input logic r);
    ent_t e;
    logic m;
    @(posedge clk);
    #1;
    inp = b;
    rst = r;
    e.n   = cyc;
    e.tag = cur_tag;
    for (int unsigned d = 0; d < ND; d++) begin
      m = model_out(d, b, r);
      e.exp[d] = m;
      if (!r || (m && !OVL[d])) begin
        hist[d]  = '0;
        since[d] = 0;
      end else begin
        hist[d]  = {hist[d][14:0], b};
        since[d] = since[d] + 1;
      end
    end
    sbq.push_back(e);
    cyc++;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send(bits[n - 1 - i], 1'b1);
  endtask

  initial begin : monitor
    ent_t          e;
    logic [ND-1:0] got;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        got = {outp_c, outp_b, outp_a};
        for (int d = 0; d < ND; d++) begin
          n_cmp++;
          if (got[d] !== e.exp[d]) begin
            n_bad++;
            $display("FAIL outp[%0d] %s cycle %0d: got %b required %b",
                     d, e.tag, e.n, got[d], e.exp[d]);
          end
        end
      end
    end
  end

  initial begin : stim
    int unsigned wait_cyc;
    for (int unsigned d = 0; d < ND; d++) begin
      hist[d]  = '0;
      since[d] = 0;
    end

    cur_tag = "reset";
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);

    cur_tag = "directed";
    send(1'b0, 1'b0);
    send_bits(32'b0100111011101010, 16);

    cur_tag = "overlap";
    send(1'b0, 1'b0);
    send_bits(32'b1011011, 7);

    cur_tag = "mismatch";
    send(1'b0, 1'b0);
    send_bits(32'b101011, 6);

    cur_tag = "midreset";
    send(1'b0, 1'b0);
    send_bits(32'b101, 3);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send_bits(32'b011, 3);

    cur_tag = "pat5";
    send(1'b0, 1'b0);
    send_bits(32'b11011011, 8);

    cur_tag = "random";
    send(1'b0, 1'b0);
    for (int unsigned i = 0; i < 1000; i++)
      send(1'($urandom_range(1, 0)), ($urandom_range(59, 0) != 0));

    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sbq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
